// File: rtl/vga_pkg.sv
// Shared constants, pixel types and swap-FSM states for the VGA framebuffer pixel pipe.
package vga_pkg;
  localparam int FB_W     = 160;
  localparam int FB_H     = 120;
  localparam int SCALE_SH = 2;
  localparam int VD       = 480;
  localparam int FB_AW    = 15;
  localparam int FB_PIX   = FB_W * FB_H;
  localparam int RAM_AW   = FB_AW + 1;

  typedef logic [7:0]  pix8_t;   // RRRGGGBB
  typedef logic [11:0] rgb12_t;  // {R4,G4,B4}

  typedef enum logic {IDLE, PENDING} swap_state_t;

  // Widen each channel by replicating its MSBs so full-scale stays full-scale.
  function automatic rgb12_t pix_to_rgb(input pix8_t p);
    return {p[7:5], p[7], p[4:2], p[4], p[1:0], p[1:0]};
  endfunction
endpackage

// File: rtl/vga_fb_ram.sv
// Two-page 8-bit framebuffer RAM: one write port, one registered read port (BRAM).
// Read data appears on the clock after an enabled read; no backpressure.
module vga_fb_ram
  import vga_pkg::*;
(
  input  logic              clk_100MHz,
  input  logic              we,
  input  logic [RAM_AW-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic              re,
  input  logic [RAM_AW-1:0] raddr,
  output logic [7:0]        rdata
);
  localparam int DEPTH = 2 * FB_PIX;

  pix8_t mem [DEPTH];

  always_ff @(posedge clk_100MHz) begin
    if (we && waddr < RAM_AW'(DEPTH)) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk_100MHz) begin
    if (re && raddr < RAM_AW'(DEPTH)) rdata <= mem[raddr];
  end
endmodule

// File: rtl/vga_fb_pixel_pipe.sv
// Double-buffered 160x120 framebuffer upscaled 4x to VGA; rgb/hsync/vsync lag inputs by 3 pix_en, no backpressure.
// Optional TEST_PATTERN_EN adds tp_sel, replacing RAM data with 64-pixel colour bars.
module vga_fb_pixel_pipe
  import vga_pkg::*;
(
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             p_tick,
  input  logic [9:0]       x_in,
  input  logic [9:0]       y_in,
  input  logic             video_on_in,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             wr_en,
  input  logic [FB_AW-1:0] wr_addr,
  input  logic [7:0]       wr_data,
  input  logic             swap_req,
`ifdef TEST_PATTERN_EN
  input  logic             tp_sel,
`endif
  output logic             swap_ack,
  output logic             front_page,
  output logic [7:0]       frame_cnt,
  output logic [11:0]      rgb,
  output logic             hsync,
  output logic             vsync
);
  logic p_tick_d, pix_en, swap_pt;

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) p_tick_d <= 1'b0;
    else       p_tick_d <= p_tick;
  end

  assign pix_en  = p_tick & ~p_tick_d;
  assign swap_pt = pix_en && (y_in == 10'(VD)) && (x_in == 10'd0);

  // Row base = (y/4)*160 as (y/4)*128 + (y/4)*32.
  logic [FB_AW-1:0] y_q, x_q, row_base;
  assign y_q      = FB_AW'(y_in >> SCALE_SH);
  assign x_q      = FB_AW'(x_in >> SCALE_SH);
  assign row_base = (y_q << 7) + (y_q << 5);

  logic [FB_AW-1:0] rd_addr_s1;
  logic             vid_s1, hs_s1, vs_s1;
  logic             vid_s2, hs_s2, vs_s2;
  logic             vid_s3, hs_s3, vs_s3;
  pix8_t            ram_q, pix_sel, pix_s3;

`ifdef TEST_PATTERN_EN
  logic [2:0] x_s1, x_s2;

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      x_s1 <= '0;
      x_s2 <= '0;
    end else if (pix_en) begin
      x_s1 <= x_in[8:6];
      x_s2 <= x_s1;
    end
  end

  assign pix_sel = tp_sel ? {x_s2, x_s2, x_s2[1:0]} : ram_q;
`else
  assign pix_sel = ram_q;
`endif

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      rd_addr_s1 <= '0;
      {vid_s1, hs_s1, vs_s1} <= '0;
      {vid_s2, hs_s2, vs_s2} <= '0;
      {vid_s3, hs_s3, vs_s3} <= '0;
      pix_s3 <= '0;
      rgb    <= '0;
      hsync  <= 1'b0;
      vsync  <= 1'b0;
    end else if (pix_en) begin
      rd_addr_s1 <= row_base + x_q;
      {vid_s1, hs_s1, vs_s1} <= {video_on_in, hsync_in, vsync_in};
      {vid_s2, hs_s2, vs_s2} <= {vid_s1, hs_s1, vs_s1};
      {vid_s3, hs_s3, vs_s3} <= {vid_s2, hs_s2, vs_s2};
      pix_s3 <= pix_sel;
      rgb    <= vid_s3 ? pix_to_rgb(pix_s3) : 12'h000;
      hsync  <= hs_s3;
      vsync  <= vs_s3;
    end
  end

  // Page 1 lives directly after page 0; the back page is always ~front_page.
  logic              ram_we;
  logic [RAM_AW-1:0] ram_waddr, ram_raddr;
  assign ram_we    = wr_en && (wr_addr < FB_AW'(FB_PIX));
  assign ram_waddr = {1'b0, wr_addr}    + (front_page ? RAM_AW'(0) : RAM_AW'(FB_PIX));
  assign ram_raddr = {1'b0, rd_addr_s1} + (front_page ? RAM_AW'(FB_PIX) : RAM_AW'(0));

  vga_fb_ram u_ram (
    .clk_100MHz (clk_100MHz),
    .we         (ram_we),
    .waddr      (ram_waddr),
    .wdata      (wr_data),
    .re         (pix_en),
    .raddr      (ram_raddr),
    .rdata      (ram_q)
  );

  swap_state_t state, state_nxt;
  logic        do_swap;

  always_comb begin
    state_nxt = state;
    do_swap   = 1'b0;
    case (state)
      IDLE:    if (swap_req) state_nxt = PENDING;
      PENDING: if (swap_pt) begin
                 do_swap   = 1'b1;
                 state_nxt = IDLE;
               end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      front_page <= 1'b0;
      swap_ack   <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      front_page <= front_page ^ do_swap;
      swap_ack   <= do_swap;
      frame_cnt  <= frame_cnt + 8'(swap_pt);
    end
  end
endmodule

// File: tb/tb_vga_fb_pixel_pipe.sv
// Bench for vga_fb_pixel_pipe: table vectors, hand sequences and a random run against a framebuffer model.
module tb_vga_fb_pixel_pipe;
  logic        clk_100MHz = 1'b0;
  logic        reset = 1'b1;
  logic        p_tick = 1'b0;
  logic [9:0]  x_in = '0, y_in = '0;
  logic        video_on_in = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
  logic        wr_en = 1'b0;
  logic [14:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        swap_req = 1'b0;
`ifdef TEST_PATTERN_EN
  logic        tp_sel = 1'b0;
`endif
  logic        swap_ack, front_page, hsync, vsync;
  logic [7:0]  frame_cnt;
  logic [11:0] rgb;

  vga_fb_pixel_pipe dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .p_tick     (p_tick),
    .x_in       (x_in),
    .y_in       (y_in),
    .video_on_in(video_on_in),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .swap_req   (swap_req),
`ifdef TEST_PATTERN_EN
    .tp_sel     (tp_sel),
`endif
    .swap_ack   (swap_ack),
    .front_page (front_page),
    .frame_cnt  (frame_cnt),
    .rgb        (rgb),
    .hsync      (hsync),
    .vsync      (vsync)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  // Reference model: two framebuffer pages, displayed page, pending request, frame count.
  typedef struct packed { logic [11:0] rgb; logic hs; logic vs; } out_t;
  logic [7:0] mem_m [0:1][0:19199];
  int   front_m = 0, pend_m = 0, fc_m = 0, swaps_m = 0, ack_cnt = 0;
  bit   tp_m = 1'b0;
  out_t exp_q[$];
  int   n_cmp = 0, n_err = 0;

  typedef struct { int x; int y; logic [11:0] exp_rgb; } vec_t;
  vec_t tbl[11];

  always @(negedge clk_100MHz) if (swap_ack === 1'b1) ack_cnt++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run still going at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] to_rgb(input logic [7:0] p);
    int r, g, b;
    r = p[7:5]; g = p[4:2]; b = p[1:0];
    return {4'(r * 2 + r / 4), 4'(g * 2 + g / 4), 4'(b * 5)};
  endfunction

  function automatic logic [11:0] model_pix(input int x, input int y);
    int i;
    if (tp_m) begin
      i = (x / 64) % 8;
      return to_rgb(8'(i * 32 + i * 4 + i % 4));
    end
    return to_rgb(mem_m[front_m][(y / 4) * 160 + x / 4]);
  endfunction

  function automatic void model_reset();
    front_m = 0; pend_m = 0; fc_m = 0;
    exp_q.delete();
    repeat (3) exp_q.push_back('0);
  endfunction

  // One pixel period (4 clocks) starting at a negedge; swap_req/wr_en are held only in the pix_en cycle.
  task automatic step(input int x, input int y, input bit hs, input bit vs,
                      input bit req, input bit wr, input int wa, input int wd);
    bit vid, sp;
    out_t e, got;
    vid = (x < 640) && (y < 480);
    x_in = 10'(x); y_in = 10'(y); video_on_in = vid; hsync_in = hs; vsync_in = vs;
    swap_req = req; wr_en = wr; wr_addr = 15'(wa); wr_data = 8'(wd); p_tick = 1'b1;
    @(negedge clk_100MHz);
    swap_req = 1'b0; wr_en = 1'b0;
    @(negedge clk_100MHz);
    p_tick = 1'b0;
    repeat (2) @(negedge clk_100MHz);
    if (wr && wa < 19200) mem_m[1 - front_m][wa] = 8'(wd);
    sp = (y == 480) && (x == 0);
    if (sp) fc_m = (fc_m + 1) % 256;
    if (pend_m != 0 && sp) begin
      front_m = 1 - front_m; pend_m = 0; swaps_m++;
    end else if (req) pend_m = 1;
    e.rgb = vid ? model_pix(x, y) : 12'h000; e.hs = hs; e.vs = vs;
    exp_q.push_back(e);
    got = exp_q.pop_front();
    chk("pipe_out", {rgb, hsync, vsync}, {got.rgb, got.hs, got.vs});
    chk("page_cnt_ack", {front_page, frame_cnt, 16'(ack_cnt)}, {1'(front_m), 8'(fc_m), 16'(swaps_m)});
  endtask

  task automatic blank3();
    repeat (3) step(700, 500, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int a, input int d);
    wr_en = 1'b1; wr_addr = 15'(a); wr_data = 8'(d);
    @(negedge clk_100MHz);
    wr_en = 1'b0;
    if (a < 19200) mem_m[1 - front_m][a] = 8'(d);
  endtask

  task automatic req();
    swap_req = 1'b1;
    @(negedge clk_100MHz);
    swap_req = 1'b0;
    pend_m = 1;
  endtask

  initial begin
    int a0;
    tbl[0]  = '{0,   0, 12'hF00};  tbl[1]  = '{3,   3, 12'hF00};
    tbl[2]  = '{2,   1, 12'hF00};  tbl[3]  = '{4,   4, 12'h00F};
    tbl[4]  = '{7,   7, 12'h00F};  tbl[5]  = '{5,   6, 12'h00F};
    tbl[6]  = '{8,   4, 12'h000};  tbl[7]  = '{4,   8, 12'h000};
    tbl[8]  = '{3,   4, 12'h000};  tbl[9]  = '{4,   3, 12'h000};
    tbl[10] = '{700, 2, 12'h000};

    repeat (3) @(negedge clk_100MHz);
    chk("reset_state", {rgb, hsync, vsync, front_page, frame_cnt, swap_ack}, 0);
    reset = 1'b0;
    model_reset();

    // Fill both pages with known random bytes so every read has a model value.
    for (int a = 0; a < 19200; a++) wr(a, $urandom_range(0, 255));
    req(); step(0, 480, 0, 0, 0, 0, 0, 0);
    for (int a = 0; a < 19200; a++) wr(a, $urandom_range(0, 255));
    req(); step(0, 480, 0, 0, 0, 0, 0, 0);

    // Back page is 1: red at (0,0) block, blue at (1,1) block, black neighbours.
    wr(0, 8'hE0); wr(161, 8'h03);
    wr(1, 0); wr(160, 0); wr(162, 0); wr(321, 0);
    a0 = ack_cnt;
    req(); step(0, 480, 0, 0, 0, 0, 0, 0);
    chk("swap_ack_once", 32'(ack_cnt - a0), 1);
    chk("front_after_swap", front_page, 1);

    foreach (tbl[i]) begin
      step(tbl[i].x, tbl[i].y, 1, 0, 0, 0, 0, 0);
      blank3();
      chk("table_rgb", rgb, tbl[i].exp_rgb);
    end

    // Back page 0: address 19200 must not reach page 1 address 0.
    wr(19200, 8'hFF);
    step(0, 0, 0, 0, 0, 0, 0, 0); blank3();
    chk("oob_write_ignored", rgb, 12'hF00);

    a0 = ack_cnt;
    req(); step(100, 100, 0, 0, 0, 0, 0, 0); req();
    step(0, 480, 0, 0, 0, 0, 0, 0);
    step(0, 480, 0, 0, 0, 0, 0, 0);
    chk("double_req_one_swap", 32'(ack_cnt - a0), 1);
    chk("double_req_page", front_page, 0);

    a0 = ack_cnt;
    step(0, 480, 0, 0, 1, 0, 0, 0);
    chk("req_at_swap_pt_waits", 32'(ack_cnt - a0), 0);
    step(0, 480, 0, 0, 0, 0, 0, 0);
    chk("req_at_swap_pt_next", 32'(ack_cnt - a0), 1);

    // Front is 1; a write in the swap cycle lands in page 0, which becomes front.
    req(); step(0, 480, 0, 0, 0, 1, 0, 8'h1C);
    step(0, 0, 0, 0, 0, 0, 0, 0); blank3();
    chk("swap_cycle_write", rgb, 12'h0F0);

    for (int n = 0; n < 400; n++) begin
      if (n % 40 == 39)
        step(0, 480, $urandom_range(0, 1), $urandom_range(0, 1), 0, 0, 0, 0);
      else
        step($urandom_range(0, 799), $urandom_range(0, 524),
             $urandom_range(0, 1), $urandom_range(0, 1),
             ($urandom_range(0, 7) == 0), $urandom_range(0, 1),
             $urandom_range(0, 19300), $urandom_range(0, 255));
    end

`ifdef TEST_PATTERN_EN
    tp_sel = 1'b1; tp_m = 1'b1;
    step(64, 10, 0, 0, 0, 0, 0, 0); blank3();
    chk("test_pattern_x64", rgb, 12'h225);
    tp_sel = 1'b0; tp_m = 1'b0;
    blank3();
`endif

    while (fc_m != 255) step(0, 480, 0, 0, 0, 0, 0, 0);
    chk("frame_cnt_255", frame_cnt, 255);
    step(0, 480, 0, 0, 0, 0, 0, 0);
    chk("frame_cnt_wrap", frame_cnt, 0);

    // Mid-frame reset with live sync, nonzero frame count and page 1 displayed.
    step(0, 480, 0, 0, 0, 0, 0, 0);
    if (front_m == 0) begin req(); step(0, 480, 0, 0, 0, 0, 0, 0); end
    step(0, 0, 1, 1, 0, 0, 0, 0);
    repeat (3) step(300, 200, 1, 1, 0, 0, 0, 0);
    @(posedge clk_100MHz); #2;
    reset = 1'b1;
    #1;
    chk("reset_midframe", {rgb, hsync, vsync, front_page, frame_cnt, swap_ack}, 0);
    @(negedge clk_100MHz); @(negedge clk_100MHz);
    reset = 1'b0;
    model_reset();
    for (int n = 0; n < 12; n++)
      step($urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(0, 1), 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
